imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Decodes the immediate format directly from opcode/funct3, so no external type select is needed.
- Sign- or zero-extends the immediate to XLEN and precomputes the PC-relative target.
- Sits between fetch and decode/execute behind a valid/ready handshake with a 2-entry skid buffer, flush, and an illegal-encoding counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous pipeline flush; drops all held entries
- in_valid  in  1  input entry valid
- in_ready  out  1  block can accept an input entry
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts the output entry
- out_fmt  out  3  format code: 0 I, 1 S, 2 B, 3 U, 4 J, 5 SHAMT, 6 CSRI, 7 NONE
- out_imm  out  XLEN  extended immediate
- out_target  out  XLEN  out_pc+out_imm for B/J/AUIPC; 0 otherwise
- out_pc  out  XLEN  PC passed through
- out_illegal  out  1  unsupported or malformed encoding
- illegal_cnt  out  CNT_W  count of accepted illegal entries; saturates at all-ones

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid, out_illegal, illegal_cnt, and both buffer entries cleared.
  - All data outputs are 0.
  - in_ready is 0 while rst is high and 1 on the first cycle after.
- Handshakes:
  - Accept on in_valid&in_ready.
  - Output transfer on out_valid&out_ready.
  - Latency is 1 cycle: an entry accepted at edge N is visible at out_* after edge N.
  - in_ready = !skid_valid and is driven from registers only, with no combinational path from out_ready.
- Storage and ordering:
  - Main output register plus one skid register.
  - Entries are delivered strictly in order.
  - When out is stalled and out_reg is full, an accepted entry goes to skid.
  - On the next out transfer, skid moves to out_reg.
  - Simultaneous accept and transfer with skid empty: the new entry replaces out_reg directly.
- out_* stability: held stable while out_valid&!out_ready.
- flush: takes priority over accept and transfer.
  - After the edge, out_valid=0, skid empty, in_ready=1.
  - An input offered in the flush cycle is dropped and not counted.
- rst has priority over flush.
- Decode (instr[6:0]):
  - LOAD, JALR, MISC-MEM -> I.
  - OP-IMM -> I, except funct3 001/101 -> SHAMT.
  - OP-IMM-32 (XLEN=64 only) -> I, except funct3 001/101 -> SHAMT.
  - STORE -> S. BRANCH -> B. LUI, AUIPC -> U. JAL -> J.
  - SYSTEM -> CSRI for funct3[2]=1, else NONE.
  - OP, OP-32 (OP-32 only when XLEN=64) -> NONE with imm 0.
  - Anything else, instr[1:0]!=2'b11, or OP-IMM-32/OP-32 when XLEN=32 -> illegal, fmt NONE, imm 0.
- Extension:
  - I/S/B/J are sign-extended from bit 11/11/12/20 to XLEN. B and J bit 0 is 0.
  - U is {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
  - SHAMT is zero-extended:
    - XLEN=32: instr[24:20]; instr[25]=1 is illegal.
    - XLEN=64 OP-IMM: instr[25:20].
    - XLEN=64 OP-IMM-32: instr[24:20]; instr[25]=1 is illegal.
  - CSRI is zero-extended instr[19:15].
- Target: pc+imm modulo 2^XLEN (wrap, no flag) for B, J and AUIPC only.
- illegal_cnt: increments at accept time of an illegal entry and holds at 2^CNT_W-1.

Decomposition:
- Package imm_pkg holds:
  - fmt_t 3-bit codes;
  - opcode localparams (LOAD, OP_IMM, OP_IMM_32, STORE, BRANCH, LUI, AUIPC, JAL, JALR, SYSTEM, MISC_MEM, OP, OP_32).
- Sub-module imm_decode: purely combinational instr -> {fmt, imm, illegal}, parametrised by XLEN.
- The top level holds the adder, skid buffer, flush and counter.

Test Plan:
- XLEN=32, 0xFFF00093 (addi -1), pc 0x0, out_ready=1 -> next cycle fmt 0, imm 0xFFFFFFFF, target 0.
- 0xFE000EE3 (beq -4) pc 0x100 -> fmt 2, imm 0xFFFFFFFC, target 0xFC; 0x0010006F (jal +2048) pc 0x1000 -> fmt 4, imm 0x800, target 0x1800.
- XLEN=32, 0x01F09093 (slli 31) -> fmt 5, imm 31; 0x02009093 -> illegal=1, fmt 7, illegal_cnt 0->1; same 0x02009093 offered during flush -> cnt unchanged.
- out_ready=0, push A, B, C back-to-back -> in_ready drops after B is accepted and C waits; out_ready=1 -> A, B, C delivered in order with out_* stable while stalled.
- With A in out_reg and B in skid, assert flush with C offered -> out_valid=0, in_ready=1, C never appears; repeat with rst instead -> all outputs and illegal_cnt = 0.
- XLEN=64, 0x800000B7 (lui 0x80000) -> imm 0xFFFFFFFF80000000; CNT_W=2, 4 illegal entries -> illegal_cnt saturates at 3.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I     = 3'd0,
    FMT_S     = 3'd1,
    FMT_B     = 3'd2,
    FMT_U     = 3'd3,
    FMT_J     = 3'd4,
    FMT_SHAMT = 3'd5,
    FMT_CSRI  = 3'd6,
    FMT_NONE  = 3'd7
  } fmt_t;

  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {format, extended immediate, illegal} decoder.
// pcrel_o marks encodings whose target is pc+imm (branch, jal, auipc).
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output fmt_t            fmt_o,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o,
  output logic            pcrel_o
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt5, shamt6, csr_uimm;

  assign opc      = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign is_shift = (f3[1:0] == 2'b01);

  assign imm_i    = {{(XLEN-11){instr_i[31]}}, instr_i[30:20]};
  assign imm_s    = {{(XLEN-11){instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
  assign imm_b    = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u    = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
  assign imm_j    = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign shamt5   = XLEN'(instr_i[24:20]);
  assign shamt6   = XLEN'(instr_i[25:20]);
  assign csr_uimm = XLEN'(instr_i[19:15]);

  // Illegal encodings leave fmt at NONE and imm at zero.
  always_comb begin
    fmt_o     = FMT_NONE;
    imm_o     = '0;
    illegal_o = 1'b0;
    pcrel_o   = 1'b0;
    if (instr_i[1:0] != 2'b11) begin
      illegal_o = 1'b1;
    end else begin
      case (opc)
        LOAD, JALR, MISC_MEM: begin
          fmt_o = FMT_I;
          imm_o = imm_i;
        end
        OP_IMM: begin
          if (!is_shift) begin
            fmt_o = FMT_I;
            imm_o = imm_i;
          end else if (IS64) begin
            fmt_o = FMT_SHAMT;
            imm_o = shamt6;
          end else if (instr_i[25]) begin
            illegal_o = 1'b1;
          end else begin
            fmt_o = FMT_SHAMT;
            imm_o = shamt5;
          end
        end
        OP_IMM_32: begin
          if (!IS64) begin
            illegal_o = 1'b1;
          end else if (!is_shift) begin
            fmt_o = FMT_I;
            imm_o = imm_i;
          end else if (instr_i[25]) begin
            illegal_o = 1'b1;
          end else begin
            fmt_o = FMT_SHAMT;
            imm_o = shamt5;
          end
        end
        STORE: begin
          fmt_o = FMT_S;
          imm_o = imm_s;
        end
        BRANCH: begin
          fmt_o   = FMT_B;
          imm_o   = imm_b;
          pcrel_o = 1'b1;
        end
        LUI: begin
          fmt_o = FMT_U;
          imm_o = imm_u;
        end
        AUIPC: begin
          fmt_o   = FMT_U;
          imm_o   = imm_u;
          pcrel_o = 1'b1;
        end
        JAL: begin
          fmt_o   = FMT_J;
          imm_o   = imm_j;
          pcrel_o = 1'b1;
        end
        SYSTEM: begin
          if (f3[2]) begin
            fmt_o = FMT_CSRI;
            imm_o = csr_uimm;
          end
        end
        OP: ;
        OP_32: illegal_o = !IS64;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode + pc-relative target behind a
// valid/ready handshake with an output register, one skid entry and an illegal counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    fmt_t            fmt;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  fmt_t            dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            dec_pcrel;
  entry_t          new_entry;

  entry_t          out_q, out_d, skid_q, skid_d;
  logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept, xfer;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (in_instr),
    .fmt_o     (dec_fmt),
    .imm_o     (dec_imm),
    .illegal_o (dec_illegal),
    .pcrel_o   (dec_pcrel)
  );

  always_comb begin
    new_entry.fmt     = dec_fmt;
    new_entry.imm     = dec_imm;
    new_entry.target  = dec_pcrel ? (in_pc + dec_imm) : '0;
    new_entry.pc      = in_pc;
    new_entry.illegal = dec_illegal;
  end

  // Ready depends only on skid occupancy (and reset), never on out_ready.
  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (xfer) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          out_d = new_entry;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept) begin
        if (out_valid_q) begin
          skid_d       = new_entry;
          skid_valid_d = 1'b1;
        end else begin
          out_d       = new_entry;
          out_valid_d = 1'b1;
        end
      end
      if (accept && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_fmt     = out_q.fmt;
  assign out_imm     = out_q.imm;
  assign out_target  = out_q.target;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32, XLEN=64 and a CNT_W=2 instance.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  // XLEN=32, CNT_W=16
  logic        a_vi, a_ir, a_ov, a_or, a_ill;
  logic [31:0] a_instr, a_pc, a_imm, a_tgt, a_opc;
  logic [2:0]  a_fmt;
  logic [15:0] a_cnt;
  // XLEN=64
  logic        b_vi, b_ir, b_ov, b_or, b_ill;
  logic [31:0] b_instr;
  logic [63:0] b_pc, b_imm, b_tgt, b_opc;
  logic [2:0]  b_fmt;
  logic [15:0] b_cnt;
  // XLEN=32, CNT_W=2
  logic        c_vi, c_ir, c_ov, c_or, c_ill;
  logic [31:0] c_instr, c_pc, c_imm, c_tgt, c_opc;
  logic [2:0]  c_fmt;
  logic [1:0]  c_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(a_vi), .in_ready(a_ir),
    .in_instr(a_instr), .in_pc(a_pc), .out_valid(a_ov), .out_ready(a_or),
    .out_fmt(a_fmt), .out_imm(a_imm), .out_target(a_tgt), .out_pc(a_opc),
    .out_illegal(a_ill), .illegal_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(b_vi), .in_ready(b_ir),
    .in_instr(b_instr), .in_pc(b_pc), .out_valid(b_ov), .out_ready(b_or),
    .out_fmt(b_fmt), .out_imm(b_imm), .out_target(b_tgt), .out_pc(b_opc),
    .out_illegal(b_ill), .illegal_cnt(b_cnt));

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dutsat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(c_vi), .in_ready(c_ir),
    .in_instr(c_instr), .in_pc(c_pc), .out_valid(c_ov), .out_ready(c_or),
    .out_fmt(c_fmt), .out_imm(c_imm), .out_target(c_tgt), .out_pc(c_opc),
    .out_illegal(c_ill), .illegal_cnt(c_cnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    a_vi = 1'b1; a_instr = 32'hFFF00093; a_pc = 32'h4; a_or = 1'b1;
    b_vi = 1'b0; b_instr = '0; b_pc = '0; b_or = 1'b1;
    c_vi = 1'b0; c_instr = '0; c_pc = '0; c_or = 1'b1;
    step(); step();
    n_cmp++; if (a_ir !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready_low: got %b want 0", a_ir); end
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", a_ov); end
    n_cmp++; if (a_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", a_cnt); end
    n_cmp++; if ({a_fmt, a_imm, a_tgt, a_opc, a_ill} !== '0) begin n_bad++; $display("FAIL rst_data: got fmt %0d imm %h tgt %h pc %h ill %b want all 0", a_fmt, a_imm, a_tgt, a_opc, a_ill); end
    rst = 1'b0; a_vi = 1'b0;
    #1;
    n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready_after: got %b want 1", a_ir); end
  endtask

  task automatic test_formats();
    logic [31:0] vi [0:13];
    logic [31:0] vp [0:13];
    logic [2:0]  vf [0:13];
    logic [31:0] vm [0:13];
    logic [31:0] vt [0:13];
    logic        vl [0:13];
    vi = '{32'hFFF00093, 32'hFE000EE3, 32'h0010006F, 32'h01F09093, 32'h12345537,
           32'h00001517, 32'h0002D073, 32'hFE112E23, 32'h002081B3, 32'h00000863,
           32'h4010D093, 32'h02009093, 32'h0000001B, 32'h00000001};
    vp = '{32'h0, 32'h100, 32'h1000, 32'h4, 32'h8, 32'h2000, 32'hC, 32'h10,
           32'h14, 32'hFFFFFFF8, 32'h18, 32'h1C, 32'h20, 32'h24};
    vf = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd3, 3'd3, 3'd6, 3'd1, 3'd7, 3'd2, 3'd5, 3'd7, 3'd7, 3'd7};
    vm = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h800, 32'd31, 32'h12345000, 32'h1000, 32'd5,
           32'hFFFFFFFC, 32'h0, 32'h10, 32'd1, 32'h0, 32'h0, 32'h0};
    vt = '{32'h0, 32'hFC, 32'h1800, 32'h0, 32'h0, 32'h3000, 32'h0, 32'h0, 32'h0,
           32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
    vl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    a_or = 1'b1;
    for (int i = 0; i < 14; i++) begin
      a_vi = 1'b1; a_instr = vi[i]; a_pc = vp[i];
      step();
      if (vl[i]) exp_cnt++;
      n_cmp++; if (a_ov !== 1'b1) begin n_bad++; $display("FAIL fmt%0d_valid: got %b want 1", i, a_ov); end
      n_cmp++; if (a_fmt !== vf[i]) begin n_bad++; $display("FAIL fmt%0d_fmt: got %0d want %0d", i, a_fmt, vf[i]); end
      n_cmp++; if (a_imm !== vm[i]) begin n_bad++; $display("FAIL fmt%0d_imm: got %h want %h", i, a_imm, vm[i]); end
      n_cmp++; if (a_tgt !== vt[i]) begin n_bad++; $display("FAIL fmt%0d_target: got %h want %h", i, a_tgt, vt[i]); end
      n_cmp++; if (a_opc !== vp[i]) begin n_bad++; $display("FAIL fmt%0d_pc: got %h want %h", i, a_opc, vp[i]); end
      n_cmp++; if (a_ill !== vl[i]) begin n_bad++; $display("FAIL fmt%0d_illegal: got %b want %b", i, a_ill, vl[i]); end
      n_cmp++; if (a_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL fmt%0d_cnt: got %0d want %0d", i, a_cnt, exp_cnt); end
    end
    a_vi = 1'b0;
    step();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL fmt_drain: got %b want 0", a_ov); end
  endtask

  task automatic test_flush_drop();
    a_vi = 1'b1; a_instr = 32'h02009093; a_pc = 32'h40; flush = 1'b1;
    step();
    flush = 1'b0; a_vi = 1'b0;
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL flushdrop_valid: got %b want 0", a_ov); end
    n_cmp++; if (a_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL flushdrop_cnt: got %0d want %0d", a_cnt, exp_cnt); end
    step();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL flushdrop_after: got %b want 0", a_ov); end
  endtask

  task automatic test_back_to_back();
    a_or = 1'b0;
    a_vi = 1'b1; a_instr = 32'hFFF00093; a_pc = 32'h10;
    step();
    n_cmp++; if (a_ov !== 1'b1 || a_opc !== 32'h10) begin n_bad++; $display("FAIL b2b_A: got v%b pc %h want v1 pc 10", a_ov, a_opc); end
    n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_A: got %b want 1", a_ir); end
    a_instr = 32'hFE000EE3; a_pc = 32'h20;
    step();
    n_cmp++; if (a_ir !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_B: got %b want 0", a_ir); end
    a_instr = 32'h0010006F; a_pc = 32'h30;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (a_opc !== 32'h10 || a_imm !== 32'hFFFFFFFF || a_fmt !== 3'd0) begin n_bad++; $display("FAIL b2b_stable%0d: got pc %h imm %h fmt %0d want pc 10 imm ffffffff fmt 0", k, a_opc, a_imm, a_fmt); end
      n_cmp++; if (a_ir !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_stall%0d: got %b want 0", k, a_ir); end
    end
    a_or = 1'b1;
    step();
    n_cmp++; if (a_ov !== 1'b1 || a_opc !== 32'h20 || a_tgt !== 32'h1C) begin n_bad++; $display("FAIL b2b_B: got v%b pc %h tgt %h want v1 pc 20 tgt 1c", a_ov, a_opc, a_tgt); end
    n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_drain: got %b want 1", a_ir); end
    step();
    a_vi = 1'b0;
    n_cmp++; if (a_ov !== 1'b1 || a_opc !== 32'h30 || a_tgt !== 32'h830 || a_fmt !== 3'd4) begin n_bad++; $display("FAIL b2b_C: got v%b pc %h tgt %h fmt %0d want v1 pc 30 tgt 830 fmt 4", a_ov, a_opc, a_tgt, a_fmt); end
    step();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", a_ov); end
  endtask

  task automatic test_flush_full();
    a_or = 1'b0;
    a_vi = 1'b1; a_instr = 32'hFFF00093; a_pc = 32'h50;
    step();
    a_instr = 32'hFE000EE3; a_pc = 32'h54;
    step();
    a_instr = 32'h0010006F; a_pc = 32'h58; flush = 1'b1;
    step();
    flush = 1'b0; a_vi = 1'b0;
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL flushfull_valid: got %b want 0", a_ov); end
    n_cmp++; if (a_ir !== 1'b1) begin n_bad++; $display("FAIL flushfull_ready: got %b want 1", a_ir); end
    a_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL flushfull_ghost%0d: got v%b pc %h want v0", k, a_ov, a_opc); end
    end
  endtask

  task automatic test_reset_full();
    a_or = 1'b0;
    a_vi = 1'b1; a_instr = 32'h00000001; a_pc = 32'h60;
    step();
    exp_cnt++;
    a_instr = 32'hFE000EE3; a_pc = 32'h64;
    step();
    n_cmp++; if (a_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rstfull_cnt_pre: got %0d want %0d", a_cnt, exp_cnt); end
    a_instr = 32'h0010006F; a_pc = 32'h68; rst = 1'b1;
    #1;
    n_cmp++; if (a_ir !== 1'b0) begin n_bad++; $display("FAIL rstfull_ready_low: got %b want 0", a_ir); end
    step();
    rst = 1'b0; a_vi = 1'b0; exp_cnt = 0;
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL rstfull_valid: got %b want 0", a_ov); end
    n_cmp++; if (a_cnt !== 16'd0) begin n_bad++; $display("FAIL rstfull_cnt: got %0d want 0", a_cnt); end
    n_cmp++; if ({a_fmt, a_imm, a_tgt, a_opc, a_ill} !== '0) begin n_bad++; $display("FAIL rstfull_data: got fmt %0d imm %h tgt %h pc %h ill %b want all 0", a_fmt, a_imm, a_tgt, a_opc, a_ill); end
    a_or = 1'b1;
    step();
    n_cmp++; if (a_ov !== 1'b0) begin n_bad++; $display("FAIL rstfull_ghost: got %b want 0", a_ov); end
  endtask

  task automatic test_xlen64();
    b_or = 1'b1;
    b_vi = 1'b1; b_instr = 32'h800000B7; b_pc = 64'h100;
    step();
    n_cmp++; if (b_imm !== 64'hFFFFFFFF80000000 || b_fmt !== 3'd3) begin n_bad++; $display("FAIL x64_lui: got imm %h fmt %0d want ffffffff80000000 fmt 3", b_imm, b_fmt); end
    n_cmp++; if (b_tgt !== 64'h0) begin n_bad++; $display("FAIL x64_lui_target: got %h want 0", b_tgt); end
    b_instr = 32'h03F09093;
    step();
    n_cmp++; if (b_imm !== 64'd63 || b_fmt !== 3'd5 || b_ill !== 1'b0) begin n_bad++; $display("FAIL x64_slli63: got imm %h fmt %0d ill %b want 3f fmt 5 ill 0", b_imm, b_fmt, b_ill); end
    b_instr = 32'h0200909B;
    step();
    n_cmp++; if (b_ill !== 1'b1 || b_fmt !== 3'd7 || b_cnt !== 16'd1) begin n_bad++; $display("FAIL x64_slliw_bad: got ill %b fmt %0d cnt %0d want ill 1 fmt 7 cnt 1", b_ill, b_fmt, b_cnt); end
    b_instr = 32'hFE000EE3; b_pc = 64'h0;
    step();
    b_vi = 1'b0;
    n_cmp++; if (b_tgt !== 64'hFFFFFFFFFFFFFFFC) begin n_bad++; $display("FAIL x64_branch_wrap: got %h want fffffffffffffffc", b_tgt); end
  endtask

  task automatic test_saturate();
    logic [1:0] want;
    c_or = 1'b1; c_vi = 1'b1; c_instr = 32'h00000000; c_pc = 32'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      want = (k >= 2) ? 2'd3 : 2'(k + 1);
      n_cmp++; if (c_cnt !== want) begin n_bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, c_cnt, want); end
    end
    c_vi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_formats();
    test_flush_drop();
    test_back_to_back();
    test_flush_full();
    test_reset_full();
    test_xlen64();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
